// File: rtl/alu_pkg.sv
// Shared ALU definitions: default width, op codes, flag bit positions, entry sizing.
// Pure declarations; no timing or flow-control behaviour.
package alu_pkg;

  localparam int ALU_WIDTH = 8;
  localparam int SEL_W     = 2;
  localparam int FLAG_W    = 3;

  localparam int FLAG_ZERO = 0;
  localparam int FLAG_NEG  = 1;
  localparam int FLAG_PAR  = 2;

  typedef enum logic [1:0] {
    OP_AND = 2'b00,
    OP_OR  = 2'b01,
    OP_XOR = 2'b10,
    OP_NOT = 2'b11
  } alu_op_e;

  // Stored entry layout is {select, flags, result}.
  function automatic int entry_width(input int width);
    return width + FLAG_W + SEL_W;
  endfunction

endpackage

// File: rtl/alu_flag_gen.sv
// Result flag generator {parity, negative, zero}; purely combinational (0 cycles).
// No flow control: flags follow the input result directly.
module alu_flag_gen
  import alu_pkg::*;
#(
  parameter int WIDTH = ALU_WIDTH
) (
  input  logic [WIDTH-1:0]  result,
  output logic [FLAG_W-1:0] flags
);

  always_comb begin
    flags            = '0;
    flags[FLAG_ZERO] = (result == '0);
    flags[FLAG_NEG]  = result[WIDTH-1];
    flags[FLAG_PAR]  = ^result;
  end

endmodule

// File: rtl/alu_result_stage.sv
// ALU result buffer: DEPTH-entry FIFO with flags captured at push; 1-cycle latency, no fall-through.
// in_ready depends only on registered level (no out_ready path); a full buffer refuses input even when popping.
module alu_result_stage
  import alu_pkg::*;
#(
  parameter int WIDTH = ALU_WIDTH,
  parameter int DEPTH = 4
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     in_valid,
  output logic                     in_ready,
  input  logic [WIDTH-1:0]         in_result,
  input  logic [1:0]               in_select,
  input  logic                     flush,
  output logic                     out_valid,
  input  logic                     out_ready,
  output logic [WIDTH-1:0]         out_result,
  output logic [1:0]               out_select,
  output logic [2:0]               out_flags,
  output logic [$clog2(DEPTH):0]   level
);

  localparam int PTR_W   = $clog2(DEPTH);
  localparam int LVL_W   = PTR_W + 1;
  localparam int ENTRY_W = entry_width(WIDTH);

  logic [ENTRY_W-1:0] mem [DEPTH];
  logic [PTR_W-1:0]   wr_ptr;
  logic [PTR_W-1:0]   rd_ptr;
  logic [FLAG_W-1:0]  in_flags;
  logic [ENTRY_W-1:0] head;
  logic               push;
  logic               pop;

  alu_flag_gen #(.WIDTH(WIDTH)) u_flag_gen (
    .result (in_result),
    .flags  (in_flags)
  );

  assign in_ready  = (level != LVL_W'(DEPTH));
  assign out_valid = (level != '0);

  // Flush overrides both sides so a same-cycle push or pop leaves no trace.
  assign push = in_valid && in_ready && !flush;
  assign pop  = out_valid && out_ready && !flush;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      level  <= '0;
    end else if (flush) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      level  <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + PTR_W'(1);
      if (pop)  rd_ptr <= rd_ptr + PTR_W'(1);
      case ({push, pop})
        2'b10:   level <= level + LVL_W'(1);
        2'b01:   level <= level - LVL_W'(1);
        default: level <= level;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      for (int i = 0; i < DEPTH; i++) mem[i] <= '0;
    end else if (push) begin
      mem[wr_ptr] <= {in_select, in_flags, in_result};
    end
  end

  assign head = mem[rd_ptr];

  // Head entry is only written when the buffer is empty, so it is stable while stalled.
  always_comb begin
    out_result = '0;
    out_flags  = '0;
    out_select = '0;
    if (out_valid) begin
      out_result = head[WIDTH-1:0];
      out_flags  = head[WIDTH +: FLAG_W];
      out_select = head[ENTRY_W-1 -: SEL_W];
    end
  end

endmodule

// File: tb/tb_alu_result_stage.sv
// Bench for alu_result_stage: queue-based reference model checked every cycle plus directed literal checks.
module tb_alu_result_stage;
  import alu_pkg::*;

  localparam int W = 8;
  localparam int D = 4;

  logic         clk = 1'b0;
  logic         rst = 1'b0;
  logic         in_valid = 1'b0;
  logic         in_ready;
  logic [W-1:0] in_result = '0;
  logic [1:0]   in_select = '0;
  logic         flush = 1'b0;
  logic         out_valid;
  logic         out_ready = 1'b0;
  logic [W-1:0] out_result;
  logic [1:0]   out_select;
  logic [2:0]   out_flags;
  logic [2:0]   level;

  int n_checks = 0;
  int n_fail   = 0;

  always #5 clk = ~clk;

  alu_result_stage #(.WIDTH(W), .DEPTH(D)) dut (
    .clk        (clk),
    .rst        (rst),
    .in_valid   (in_valid),
    .in_ready   (in_ready),
    .in_result  (in_result),
    .in_select  (in_select),
    .flush      (flush),
    .out_valid  (out_valid),
    .out_ready  (out_ready),
    .out_result (out_result),
    .out_select (out_select),
    .out_flags  (out_flags),
    .level      (level)
  );

  typedef struct {
    logic [W-1:0] res;
    logic [1:0]   sel;
  } ent_t;

  ent_t model_q[$];

  function automatic logic [2:0] exp_flags(input logic [W-1:0] r);
    logic par, neg, zero;
    par  = ($countones(r) % 2) == 1;
    neg  = (r >= 8'd128);
    zero = (r == 0);
    return {par, neg, zero};
  endfunction

  task automatic chk(input string name, input int act, input int exp);
    n_checks++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Reference model: occupancy decided before the edge; full blocks push even with a pop.
  always @(posedge clk or negedge rst) begin
    int  n;
    ent_t e;
    if (!rst) begin
      model_q.delete();
    end else begin
      n = model_q.size();
      if (flush) begin
        model_q.delete();
      end else begin
        if (out_ready && n > 0) void'(model_q.pop_front());
        if (in_valid && n < D) begin
          e.res = in_result;
          e.sel = in_select;
          model_q.push_back(e);
        end
      end
    end
  end

  always @(negedge clk) begin
    if (rst) begin
      if (model_q.size() == 0) begin
        chk("m_out_result", int'(out_result), 0);
        chk("m_out_select", int'(out_select), 0);
        chk("m_out_flags",  int'(out_flags),  0);
      end else begin
        chk("m_out_result", int'(out_result), int'(model_q[0].res));
        chk("m_out_select", int'(out_select), int'(model_q[0].sel));
        chk("m_out_flags",  int'(out_flags),  int'(exp_flags(model_q[0].res)));
      end
      chk("m_level",     int'(level),     model_q.size());
      chk("m_out_valid", int'(out_valid), int'(model_q.size() != 0));
      chk("m_in_ready",  int'(in_ready),  int'(model_q.size() != D));
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic push_one(input logic [W-1:0] r, input logic [1:0] s);
    in_valid  = 1'b1;
    in_result = r;
    in_select = s;
    step();
    in_valid  = 1'b0;
  endtask

  task automatic do_flush();
    flush = 1'b1;
    step();
    flush = 1'b0;
  endtask

  logic [W-1:0] fill_vals [4];
  logic [W-1:0] seq [12];
  logic [W-1:0] fv [3];
  logic [1:0]   fs [3];
  logic [2:0]   ff [3];

  initial begin
    fill_vals = '{8'h11, 8'h22, 8'h33, 8'h44};
    fv = '{8'h00, 8'h80, 8'h07};
    fs = '{OP_AND, OP_XOR, OP_OR};
    ff = '{3'b001, 3'b110, 3'b100};

    // Reset state
    step();
    step();
    chk("rst_level",     int'(level),      0);
    chk("rst_out_valid", int'(out_valid),  0);
    chk("rst_in_ready",  int'(in_ready),   1);
    chk("rst_out_res",   int'(out_result), 0);
    #2 rst = 1'b1;
    step();

    // Flags for known values; also no fall-through on the push cycle
    for (int i = 0; i < 3; i++) begin
      in_valid  = 1'b1;
      in_result = fv[i];
      in_select = fs[i];
      #1;
      chk("no_fallthrough", int'(out_valid), 0);
      step();
      in_valid = 1'b0;
      chk("flags_val", int'(out_flags),  int'(ff[i]));
      chk("flags_sel", int'(out_select), int'(fs[i]));
      chk("flags_res", int'(out_result), int'(fv[i]));
      do_flush();
    end

    // Fill to full, refused fifth push, in-order drain
    out_ready = 1'b0;
    for (int i = 0; i < 4; i++) push_one(fill_vals[i], OP_OR);
    chk("fill_level",    int'(level),    4);
    chk("fill_in_ready", int'(in_ready), 0);
    in_valid  = 1'b1;
    in_result = 8'h55;
    step();
    in_valid = 1'b0;
    chk("fill_5th_refused", int'(level), 4);
    out_ready = 1'b1;
    for (int i = 0; i < 4; i++) begin
      chk("drain_order", int'(out_result), int'(fill_vals[i]));
      step();
    end
    out_ready = 1'b0;
    chk("drain_empty", int'(out_valid), 0);

    // Full with simultaneous pop: pop only
    for (int i = 1; i <= 4; i++) push_one(W'(i), OP_NOT);
    in_valid  = 1'b1;
    in_result = 8'h99;
    out_ready = 1'b1;
    step();
    in_valid  = 1'b0;
    out_ready = 1'b0;
    chk("fullpop_level", int'(level),      3);
    chk("fullpop_head",  int'(out_result), 2);
    do_flush();

    // Concurrent push/pop at level 2 across pointer wrap
    seq[0] = 8'h40;
    seq[1] = 8'h41;
    for (int i = 0; i < 10; i++) seq[i+2] = W'(8'h50 + i);
    push_one(seq[0], OP_XOR);
    push_one(seq[1], OP_XOR);
    in_valid  = 1'b1;
    out_ready = 1'b1;
    for (int i = 0; i < 10; i++) begin
      in_result = seq[i+2];
      chk("flow_head", int'(out_result), int'(seq[i]));
      step();
      chk("flow_level", int'(level), 2);
    end
    in_valid = 1'b0;
    for (int i = 10; i < 12; i++) begin
      chk("flow_tail", int'(out_result), int'(seq[i]));
      step();
    end
    out_ready = 1'b0;

    // Flush with same-cycle push and pop
    for (int i = 0; i < 3; i++) push_one(W'(8'hA1 + i), OP_AND);
    chk("flush_pre_level", int'(level), 3);
    flush     = 1'b1;
    in_valid  = 1'b1;
    in_result = 8'hEE;
    out_ready = 1'b1;
    step();
    flush    = 1'b0;
    in_valid = 1'b0;
    chk("flush_level",     int'(level),     0);
    chk("flush_out_valid", int'(out_valid), 0);
    for (int i = 0; i < 4; i++) begin
      step();
      chk("flush_no_emerge", int'(out_valid), 0);
    end
    out_ready = 1'b0;

    // Asynchronous reset mid-stream at level 3
    for (int i = 0; i < 3; i++) push_one(W'(8'hC1 + i), OP_OR);
    chk("prerst_level", int'(level), 3);
    #2 rst = 1'b0;
    #1;
    chk("arst_level",     int'(level),      0);
    chk("arst_out_valid", int'(out_valid),  0);
    chk("arst_out_res",   int'(out_result), 0);
    chk("arst_out_flags", int'(out_flags),  0);
    chk("arst_out_sel",   int'(out_select), 0);
    chk("arst_in_ready",  int'(in_ready),   1);
    @(negedge clk);
    #1 rst = 1'b1;
    step();
    push_one(8'h12, OP_XOR);
    chk("postrst_level", int'(level),      1);
    chk("postrst_head",  int'(out_result), 8'h12);
    do_flush();

    // Randomized traffic against the model
    for (int i = 0; i < 3000; i++) begin
      in_valid  = ($urandom_range(0, 3) != 0);
      out_ready = ($urandom_range(0, 2) != 0);
      flush     = ($urandom_range(0, 40) == 0);
      in_result = W'($urandom);
      in_select = 2'($urandom);
      step();
    end
    in_valid  = 1'b0;
    out_ready = 1'b0;
    flush     = 1'b0;
    step();

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
